detect_alert_ctrl: RTL and testbench



---
 rtl/detect_alert_pkg.sv | 16 +
 rtl/detect_alert_ctrl_tone_gen.sv | 31 +++
 rtl/detect_alert_ctrl.sv | 135 +++++++++++++
 tb/tb_detect_alert_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/detect_alert_pkg.sv
// Shared types and helpers for the detection-confirmation / alert controller.
// Build option: define ALERT_PULSED_EN for the on/off pulsed alert pattern.
package detect_alert_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALERT,
    ST_HOLDOFF
  } state_t;

  // Counter width able to hold 0..p, never narrower than one bit.
  function automatic int cnt_w(input int p);
    return (p < 1) ? 1 : $clog2(p + 1);
  endfunction

endpackage

// File: rtl/detect_alert_ctrl_tone_gen.sv
// Square-wave tone source: toggles every TONE_HALF cycles while enabled,
// counter and output cleared whenever en is low.
module tone_gen
  import detect_alert_pkg::*;
#(
  parameter int TONE_HALF = 6250
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tone
);

  localparam int W = cnt_w(TONE_HALF);
  localparam logic [W-1:0] LAST = W'(TONE_HALF - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/detect_alert_ctrl.sv
// Confirms runs of positive detector frames, then beeps and holds off.
// Build option: ALERT_PULSED_EN gates the tone in PULSE_CYCLES on/off slots.
module detect_alert_ctrl
  import detect_alert_pkg::*;
#(
  parameter int CONFIRM_N      = 2,
  parameter int BEEP_CYCLES    = 50000000,
  parameter int TONE_HALF      = 6250,
  parameter int HOLDOFF_CYCLES = 25000000,
  parameter int PULSE_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic result_dv,
  input  logic result,
  input  logic vad_in,
  output logic beep,
  output logic alert,
  output logic led_active,
  output logic led_vad,
  output logic led_hb
);

  localparam int RW = cnt_w(CONFIRM_N);
  localparam int DW = cnt_w(BEEP_CYCLES);
  localparam int HW = cnt_w(HOLDOFF_CYCLES);

  localparam logic [RW-1:0] RUN_LAST = RW'(CONFIRM_N - 1);
  localparam logic [DW-1:0] DUR_LAST = DW'(BEEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t        state;
  logic [RW-1:0] run;
  logic [DW-1:0] dur;
  logic [HW-1:0] hold;
  logic          tone;

`ifdef ALERT_PULSED_EN
  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam logic [PW-1:0] SLOT_LAST = PW'(PULSE_CYCLES - 1);

  logic [PW-1:0] slot;
  logic          off;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      run        <= '0;
      dur        <= '0;
      hold       <= '0;
      alert      <= 1'b0;
      led_active <= 1'b0;
      led_hb     <= 1'b0;
      led_vad    <= 1'b0;
`ifdef ALERT_PULSED_EN
      slot       <= '0;
      off        <= 1'b0;
`endif
    end else begin
      led_vad <= vad_in;
      if (result_dv) begin
        led_active <= result;
        led_hb     <= ~led_hb;
      end
      unique case (state)
        ST_IDLE: begin
          if (result_dv) begin
            if (!result) begin
              run <= '0;
            end else if (run == RUN_LAST) begin
              state <= ST_ALERT;
              alert <= 1'b1;
              run   <= '0;
              dur   <= '0;
`ifdef ALERT_PULSED_EN
              slot  <= '0;
              off   <= 1'b0;
`endif
            end else begin
              run <= run + 1'b1;
            end
          end
        end
        ST_ALERT: begin
`ifdef ALERT_PULSED_EN
          if (slot == SLOT_LAST) begin
            slot <= '0;
            off  <= ~off;
          end else begin
            slot <= slot + 1'b1;
          end
`endif
          if (dur == DUR_LAST) begin
            alert <= 1'b0;
            dur   <= '0;
            hold  <= '0;
            if (HOLDOFF_CYCLES == 0) state <= ST_IDLE;
            else state <= ST_HOLDOFF;
          end else begin
            dur <= dur + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          run <= '0;
          if (hold == HOLD_LAST) begin
            state <= ST_IDLE;
            hold  <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk  (clk),
    .reset(reset),
    .en   (alert),
    .tone (tone)
  );

  // Gating with alert keeps beep silent on the cycle the tone clears.
`ifdef ALERT_PULSED_EN
  assign beep = tone & alert & ~off;
`else
  assign beep = tone & alert;
`endif

endmodule

// File: tb/tb_detect_alert_ctrl.sv
// Directed bench for detect_alert_ctrl with small parameters.
// Expected values are hand-derived from the controller's timing rules.
module tb_detect_alert_ctrl;

  localparam int CONFIRM_N = 3;
  localparam int BEEP_CYCLES = 100;
  localparam int TONE_HALF = 5;
  localparam int HOLDOFF_CYCLES = 20;
  localparam int PULSE_CYCLES = 25;
`ifdef ALERT_PULSED_EN
  localparam int RISES = 4;
`else
  localparam int RISES = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic result_dv = 1'b0;
  logic result = 1'b0;
  logic vad_in = 1'b0;
  logic beep, alert, led_active, led_vad, led_hb;

  int errors = 0;
  int checks = 0;
  logic hb_exp = 1'b0;
  int n, rises, first;

  always #5 clk = ~clk;

  detect_alert_ctrl #(
    .CONFIRM_N     (CONFIRM_N),
    .BEEP_CYCLES   (BEEP_CYCLES),
    .TONE_HALF     (TONE_HALF),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .PULSE_CYCLES  (PULSE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .result_dv (result_dv),
    .result    (result),
    .vad_in    (vad_in),
    .beep      (beep),
    .alert     (alert),
    .led_active(led_active),
    .led_vad   (led_vad),
    .led_hb    (led_hb)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic r);
    result_dv = 1'b1;
    result = r;
    tick();
    result_dv = 1'b0;
    result = 1'b0;
    hb_exp = ~hb_exp;
    check("led_active", {31'd0, led_active}, {31'd0, r});
    check("led_hb", {31'd0, led_hb}, {31'd0, hb_exp});
  endtask

  task automatic gap();
    repeat (9) tick();
  endtask

  // Counts alert-high cycles and beep rising edges, bounded.
  task automatic measure(output int cnt, output int rs, output int fst);
    logic prev;
    prev = 1'b0;
    cnt = 0;
    rs = 0;
    fst = -1;
    for (int i = 0; i < 300; i++) begin
      if (!alert) break;
      if (beep && !prev) begin
        if (fst < 0) fst = cnt;
        rs++;
      end
      prev = beep;
      cnt++;
      tick();
    end
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst_alert", {31'd0, alert}, 0);
    check("rst_beep", {31'd0, beep}, 0);
    check("rst_led_active", {31'd0, led_active}, 0);
    check("rst_led_hb", {31'd0, led_hb}, 0);
    check("rst_led_vad", {31'd0, led_vad}, 0);

    // 1,1,1 triggers, alert for 100 cycles, tone every 5
    strobe(1); gap();
    strobe(1); gap();
    check("t1_pre", {31'd0, alert}, 0);
    strobe(1);
    check("t1_rise", {31'd0, alert}, 1);
    measure(n, rises, first);
    check("t1_len", n, BEEP_CYCLES);
    check("t1_rises", rises, RISES);
    check("t1_first", first, TONE_HALF);
    check("t1_beep_off", {31'd0, beep}, 0);

    // strobe on the HOLDOFF->IDLE cycle is ignored
    repeat (HOLDOFF_CYCLES - 1) tick();
    strobe(1);
    strobe(1);
    strobe(1);
    check("hold_edge", {31'd0, alert}, 0);
    strobe(1);
    check("b2b_trig", {31'd0, alert}, 1);
    measure(n, rises, first);
    check("t2_len", n, BEEP_CYCLES);

    // results during holdoff do not count
    strobe(1); repeat (4) tick();
    strobe(1); repeat (4) tick();
    strobe(1); repeat (4) tick();
    check("hold_ign", {31'd0, alert}, 0);
    repeat (10) tick();
    strobe(1); gap();
    strobe(1); gap();
    check("post_hold2", {31'd0, alert}, 0);
    strobe(1);
    check("post_hold3", {31'd0, alert}, 1);
    measure(n, rises, first);
    repeat (HOLDOFF_CYCLES + 2) tick();

    // a zero breaks the run
    strobe(1); gap();
    strobe(1); gap();
    strobe(0); gap();
    strobe(1); gap();
    strobe(1); gap();
    check("run_break", {31'd0, alert}, 0);
    strobe(1);
    check("run_resume", {31'd0, alert}, 1);
    measure(n, rises, first);
    check("t3_len", n, BEEP_CYCLES);
    repeat (HOLDOFF_CYCLES + 2) tick();

    // reset 40 cycles into ALERT
    strobe(1); gap();
    strobe(1); gap();
    strobe(1);
    repeat (40) tick();
    check("pre_rst_alert", {31'd0, alert}, 1);
    vad_in = 1'b1;
    reset = 1'b1;
    tick();
    hb_exp = 1'b0;
    check("mid_rst_alert", {31'd0, alert}, 0);
    check("mid_rst_beep", {31'd0, beep}, 0);
    check("mid_rst_active", {31'd0, led_active}, 0);
    check("mid_rst_hb", {31'd0, led_hb}, 0);
    check("mid_rst_vad", {31'd0, led_vad}, 0);
    reset = 1'b0;
    vad_in = 1'b0;
    tick();
    strobe(1); gap();
    strobe(1); gap();
    check("re_pre", {31'd0, alert}, 0);
    strobe(1);
    check("re_trig", {31'd0, alert}, 1);
    measure(n, rises, first);
    check("re_len", n, BEEP_CYCLES);
    repeat (HOLDOFF_CYCLES + 2) tick();

    // LED tracking over six strobes and vad latency
    hb_exp = led_hb;
    strobe(1); gap();
    strobe(0); gap();
    strobe(1); gap();
    strobe(1); gap();
    strobe(0); gap();
    strobe(0); gap();
    check("led_no_alert", {31'd0, alert}, 0);
    vad_in = 1'b1;
    check("vad_before", {31'd0, led_vad}, 0);
    tick();
    check("vad_after", {31'd0, led_vad}, 1);
    vad_in = 1'b0;
    tick();
    check("vad_fall", {31'd0, led_vad}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
